// File: rtl/apb_rx_fifo_slave_pkg.sv
// Shared definitions for the UART receive-path APB slave: register map,
// error flag positions, capture FSM states and the RXDATA justification helper.
package apb_rx_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_ERR    = 3'd1;
  localparam logic [2:0] ADDR_BP_LO  = 3'd2;
  localparam logic [2:0] ADDR_BP_HI  = 3'd3;
  localparam logic [2:0] ADDR_DSIZE  = 3'd4;
  localparam logic [2:0] ADDR_IE     = 3'd5;
  localparam logic [2:0] ADDR_RXDATA = 3'd6;
  localparam logic [2:0] ADDR_COUNT  = 3'd7;

  localparam int unsigned ERR_FRAMING  = 0;
  localparam int unsigned ERR_OVERRUN  = 1;
  localparam int unsigned ERR_OVERFLOW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_e;

  // The receiver shifts LSB-first into bit 7, so short characters sit in the top bits.
  function automatic logic [7:0] rx_justify(input logic [7:0] data, input logic [3:0] size);
    logic [7:0] res;
    case (size)
      4'd5:    res = data >> 3'd3;
      4'd6:    res = data >> 3'd2;
      4'd7:    res = data >> 3'd1;
      4'd8:    res = data;
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/apb_rx_fifo_slave_if.sv
// APB bus bundle between the master and the receive-path slave.
interface apb_rx_fifo_slave_if;
  logic       psel;
  logic       penable;
  logic [2:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pslverr
  );
endinterface

// File: rtl/apb_rx_fifo_slave_fifo.sv
// Synchronous FIFO with a separate occupancy counter; head is shown on rdata_o.
// Pushes when full and pops when empty are ignored.
module rx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == CNT_W'(0));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (n_rst && do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/apb_rx_fifo_slave.sv
// APB slave for the UART receive path: autonomous capture from rx_data_buff into
// a FIFO, sticky W1C error flags, maskable level interrupt and receiver configuration.
module apb_rx_fifo_slave
  import apb_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BP_W       = 14,
  parameter int unsigned BP_RESET   = 10,
  parameter int unsigned DS_RESET   = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [7:0]            rx_data_i,
  input  logic                  data_ready_i,
  input  logic                  overrun_error_i,
  input  logic                  framing_error_i,
  output logic                  data_read_o,
  apb_rx_fifo_slave_if.slave    apb,
  output logic [3:0]            data_size_o,
  output logic [BP_W-1:0]       bit_period_o,
  output logic                  irq_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  cap_state_e       state_q, state_d;
  logic [BP_W-1:0]  bp_q, bp_d;
  logic [3:0]       ds_q, ds_d;
  logic [2:0]       ie_q, ie_d;
  logic [2:0]       err_q, err_d;
  logic             irq_q, irq_d;

  logic             push_s, pop_s, full_s, empty_s, ovf_s, data_read_s;
  logic [7:0]       head_s;
  logic [CNT_W-1:0] count_s;
  logic             access_s, wr_s, rd_s, wr_err_s, rd_err_s, wr_ok_s;
  logic [2:0]       err_set_s, err_clr_s;
  logic [7:0]       prdata_s;
  logic             pslverr_s;

  assign access_s = apb.psel & apb.penable;
  assign wr_s     = access_s & apb.pwrite;
  assign rd_s     = access_s & ~apb.pwrite;
  assign wr_err_s = wr_s & ((apb.paddr == ADDR_STATUS) || (apb.paddr == ADDR_RXDATA) ||
                            (apb.paddr == ADDR_COUNT));
  assign rd_err_s = rd_s & (apb.paddr == ADDR_RXDATA) & empty_s;
  assign wr_ok_s  = wr_s & ~wr_err_s;
  assign pop_s    = rd_s & (apb.paddr == ADDR_RXDATA) & ~empty_s;

  rx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (rx_data_i),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // Capture FSM: acknowledge in the push cycle, then wait for data_ready to fall.
  always_comb begin
    state_d     = state_q;
    push_s      = 1'b0;
    data_read_s = 1'b0;
    ovf_s       = 1'b0;
    if (n_rst) begin
      case (state_q)
        IDLE: begin
          if (data_ready_i && !full_s) begin
            push_s      = 1'b1;
            data_read_s = 1'b1;
            state_d     = HOLD;
          end else if (data_ready_i) begin
            ovf_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (!data_ready_i) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  always_comb begin
    bp_d      = bp_q;
    ds_d      = ds_q;
    ie_d      = ie_q;
    err_set_s = 3'b000;
    err_clr_s = 3'b000;
    err_set_s[ERR_FRAMING]  = framing_error_i;
    err_set_s[ERR_OVERRUN]  = overrun_error_i;
    err_set_s[ERR_OVERFLOW] = ovf_s;
    if (wr_ok_s) begin
      case (apb.paddr)
        ADDR_ERR:   err_clr_s = apb.pwdata[2:0];
        ADDR_BP_LO: bp_d[7:0] = apb.pwdata;
        ADDR_BP_HI: bp_d[BP_W-1:8] = apb.pwdata[BP_W-9:0];
        ADDR_DSIZE: ds_d = apb.pwdata[3:0];
        ADDR_IE:    ie_d = apb.pwdata[2:0];
        default:    bp_d = bp_q;
      endcase
    end else begin
      err_clr_s = 3'b000;
    end
    // Set beats clear when both land in the same cycle.
    err_d = (err_q & ~err_clr_s) | err_set_s;
    irq_d = (ie_q[0] & ~empty_s) |
            (ie_q[1] & (err_q[ERR_FRAMING] | err_q[ERR_OVERRUN])) |
            (ie_q[2] & err_q[ERR_OVERFLOW]);
  end

  always_comb begin
    prdata_s  = 8'h00;
    pslverr_s = wr_err_s | rd_err_s;
    if (rd_s) begin
      case (apb.paddr)
        ADDR_STATUS: prdata_s = {5'b00000, irq_q, full_s, ~empty_s};
        ADDR_ERR:    prdata_s = {5'b00000, err_q};
        ADDR_BP_LO:  prdata_s = bp_q[7:0];
        ADDR_BP_HI:  prdata_s = 8'(bp_q[BP_W-1:8]);
        ADDR_DSIZE:  prdata_s = {4'b0000, ds_q};
        ADDR_IE:     prdata_s = {5'b00000, ie_q};
        ADDR_RXDATA: prdata_s = empty_s ? 8'h00 : rx_justify(head_s, ds_q);
        ADDR_COUNT:  prdata_s = 8'(count_s);
        default:     prdata_s = 8'h00;
      endcase
    end else begin
      prdata_s = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      bp_q    <= BP_W'(BP_RESET);
      ds_q    <= 4'(DS_RESET);
      ie_q    <= 3'b000;
      err_q   <= 3'b000;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bp_q    <= bp_d;
      ds_q    <= ds_d;
      ie_q    <= ie_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign data_read_o  = data_read_s;
  assign apb.prdata   = prdata_s;
  assign apb.pslverr  = pslverr_s;
  assign data_size_o  = ds_q;
  assign bit_period_o = bp_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_apb_rx_fifo_slave.sv
// Directed bench for apb_rx_fifo_slave: bus tasks, an rx_data_buff handshake model
// and hand-computed expectations checked with immediate assertions.
module tb_apb_rx_fifo_slave;
  import apb_rx_pkg::*;

  logic        clk;
  logic        n_rst;
  logic [7:0]  rx_data;
  logic        data_ready;
  logic        overrun_error;
  logic        framing_error;
  logic        data_read;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic        irq;

  int checks = 0;
  int errors = 0;

  apb_rx_fifo_slave_if apb ();

  apb_rx_fifo_slave #(
    .FIFO_DEPTH (8),
    .BP_W       (14),
    .BP_RESET   (10),
    .DS_RESET   (8)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .rx_data_i       (rx_data),
    .data_ready_i    (data_ready),
    .overrun_error_i (overrun_error),
    .framing_error_i (framing_error),
    .data_read_o     (data_read),
    .apb             (apb),
    .data_size_o     (data_size),
    .bit_period_o    (bit_period),
    .irq_o           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d, output logic err);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    err = apb.pslverr;
    @(posedge clk);
    #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic err);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    d   = apb.prdata;
    err = apb.pslverr;
    @(posedge clk);
    #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // rx_data_buff model: hold data_ready until acknowledged; lat = cycles waited.
  task automatic send_char(input logic [7:0] c, output int lat);
    logic got;
    got = 1'b0;
    lat = -1;
    @(negedge clk);
    rx_data = c; data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (data_read === 1'b1) begin
        got = 1'b1;
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("ack_one_cycle", {31'd0, data_read}, 32'd0);
  endtask

  logic [7:0] rd;
  logic       er;
  int         lat;

  initial begin
    n_rst = 1'b0; rx_data = 8'h00; data_ready = 1'b0;
    overrun_error = 1'b0; framing_error = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 3'd0; apb.pwdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("rst_bit_period", 32'(bit_period), 32'd10);
    chk("rst_data_size", 32'(data_size), 32'd8);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pslverr", 32'(apb.pslverr), 32'd0);
    chk("rst_prdata_idle", 32'(apb.prdata), 32'd0);
    apb_read(ADDR_COUNT, rd, er);
    chk("rst_count", 32'(rd), 32'd0);
    chk("rst_count_err", 32'(er), 32'd0);

    // bit_period split across two registers
    apb_write(ADDR_BP_HI, 8'hFF, er);
    chk("bphi_wr_err", 32'(er), 32'd0);
    apb_write(ADDR_BP_LO, 8'h34, er);
    apb_read(ADDR_BP_HI, rd, er);
    chk("bphi_rd", 32'(rd), 32'h3F);
    apb_read(ADDR_BP_LO, rd, er);
    chk("bplo_rd", 32'(rd), 32'h34);
    chk("bit_period", 32'(bit_period), 32'h3F34);

    // capture three characters and pop them right-justified for 5-bit size
    send_char(8'hA8, lat);
    send_char(8'h50, lat);
    send_char(8'hF8, lat);
    apb_read(ADDR_COUNT, rd, er);
    chk("count3", 32'(rd), 32'd3);
    apb_read(ADDR_STATUS, rd, er);
    chk("status_ne", 32'(rd), 32'h01);
    apb_write(ADDR_DSIZE, 8'h05, er);
    chk("data_size5", 32'(data_size), 32'd5);
    apb_read(ADDR_RXDATA, rd, er);
    chk("pop0", 32'(rd), 32'h15);
    chk("pop0_err", 32'(er), 32'd0);
    apb_read(ADDR_RXDATA, rd, er);
    chk("pop1", 32'(rd), 32'h0A);
    apb_read(ADDR_RXDATA, rd, er);
    chk("pop2", 32'(rd), 32'h1F);
    apb_read(ADDR_COUNT, rd, er);
    chk("count0", 32'(rd), 32'd0);

    // fill, then overflow with the overflow interrupt enabled
    apb_write(ADDR_IE, 8'h04, er);
    for (int i = 0; i < 8; i++) send_char(8'hC0 + 8'(i), lat);
    apb_read(ADDR_COUNT, rd, er);
    chk("count_full", 32'(rd), 32'd8);
    apb_read(ADDR_STATUS, rd, er);
    chk("status_full", 32'(rd), 32'h03);
    @(negedge clk);
    rx_data = 8'hEE; data_ready = 1'b1;
    #1;
    chk("ovf_no_ack", 32'(data_read), 32'd0);
    chk("irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    data_ready = 1'b0;
    #1;
    chk("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    #1;
    chk("irq_set", 32'(irq), 32'd1);
    apb_read(ADDR_COUNT, rd, er);
    chk("count_ovf", 32'(rd), 32'd8);
    apb_read(ADDR_ERR, rd, er);
    chk("err_ovf", 32'(rd), 32'h04);
    apb_read(ADDR_STATUS, rd, er);
    chk("status_irq", 32'(rd), 32'h07);
    apb_write(ADDR_ERR, 8'h04, er);
    apb_read(ADDR_ERR, rd, er);
    chk("err_cleared", 32'(rd), 32'h00);
    chk("irq_cleared", 32'(irq), 32'd0);

    // set wins over clear; overrun flag
    @(negedge clk);
    framing_error = 1'b1;
    apb_write(ADDR_ERR, 8'h01, er);
    apb_read(ADDR_ERR, rd, er);
    chk("err_set_wins", 32'(rd), 32'h01);
    framing_error = 1'b0;
    apb_write(ADDR_ERR, 8'h01, er);
    apb_read(ADDR_ERR, rd, er);
    chk("err_framing_clr", 32'(rd), 32'h00);
    @(negedge clk);
    overrun_error = 1'b1;
    @(negedge clk);
    overrun_error = 1'b0;
    apb_read(ADDR_ERR, rd, er);
    chk("err_overrun", 32'(rd), 32'h02);
    apb_write(ADDR_ERR, 8'h02, er);

    // illegal writes leave state alone
    apb_write(ADDR_COUNT, 8'h00, er);
    chk("wr_count_err", 32'(er), 32'd1);
    apb_write(ADDR_STATUS, 8'hFF, er);
    chk("wr_status_err", 32'(er), 32'd1);
    apb_read(ADDR_COUNT, rd, er);
    chk("count_kept", 32'(rd), 32'd8);

    // drain: unsupported size reads unshifted, then full 8-bit
    apb_write(ADDR_DSIZE, 8'h04, er);
    apb_read(ADDR_RXDATA, rd, er);
    chk("pop_size4", 32'(rd), 32'hC0);
    apb_write(ADDR_DSIZE, 8'h08, er);
    for (int i = 1; i < 8; i++) begin
      apb_read(ADDR_RXDATA, rd, er);
      chk("drain", 32'(rd), 32'hC0 + 32'(i));
    end
    apb_read(ADDR_RXDATA, rd, er);
    chk("empty_rd_data", 32'(rd), 32'h00);
    chk("empty_rd_err", 32'(er), 32'd1);
    apb_read(ADDR_COUNT, rd, er);
    chk("count_empty", 32'(rd), 32'd0);

    // push and pop in the same cycle
    send_char(8'h3C, lat);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = ADDR_RXDATA;
    @(negedge clk);
    apb.penable = 1'b1; rx_data = 8'h5A; data_ready = 1'b1;
    #1;
    chk("pp_ack", 32'(data_read), 32'd1);
    chk("pp_head", 32'(apb.prdata), 32'h3C);
    chk("pp_err", 32'(apb.pslverr), 32'd0);
    @(posedge clk);
    #1;
    apb.psel = 1'b0; apb.penable = 1'b0; data_ready = 1'b0;
    apb_read(ADDR_COUNT, rd, er);
    chk("pp_count", 32'(rd), 32'd1);
    apb_read(ADDR_RXDATA, rd, er);
    chk("pp_next", 32'(rd), 32'h5A);

    // reset in the access phase of a BP_LO write with two entries queued
    apb_write(ADDR_DSIZE, 8'h06, er);
    send_char(8'h11, lat);
    send_char(8'h22, lat);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = ADDR_BP_LO; apb.pwdata = 8'h55;
    @(negedge clk);
    apb.penable = 1'b1; n_rst = 1'b0;
    @(posedge clk);
    #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    data_ready = 1'b1;
    #1;
    chk("rst_no_ack", 32'(data_read), 32'd0);
    data_ready = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("mid_rst_bp", 32'(bit_period), 32'd10);
    chk("mid_rst_ds", 32'(data_size), 32'd8);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    apb_read(ADDR_COUNT, rd, er);
    chk("mid_rst_count", 32'(rd), 32'd0);
    send_char(8'h77, lat);
    chk("mid_rst_idle", 32'(lat), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
